// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: reg_num read/write registers exposed as a flat bus,
// with a per-register write pulse and SLVERR for any address outside the bank.
module axi4_lite_slave_regs #(
  parameter int datawidth = 32,
  parameter int addrwidth = 32,
  parameter int reg_num   = 16
) (
  input  logic                          s_axi_aclk_in,
  input  logic                          s_axi_areset_in,
  input  logic [addrwidth-1:0]          s_axi_awaddr_in,
  input  logic                          s_axi_awvalid_in,
  output logic                          s_axi_awready_out,
  input  logic [datawidth-1:0]          s_axi_wdata_in,
  input  logic [datawidth/8-1:0]        s_axi_wstrb_in,
  input  logic                          s_axi_wvalid_in,
  output logic                          s_axi_wready_out,
  output logic [1:0]                    s_axi_bresp_out,
  output logic                          s_axi_bvalid_out,
  input  logic                          s_axi_bready_in,
  input  logic [addrwidth-1:0]          s_axi_araddr_in,
  input  logic                          s_axi_arvalid_in,
  output logic                          s_axi_arready_out,
  output logic [datawidth-1:0]          s_axi_rdata_out,
  output logic [1:0]                    s_axi_rresp_out,
  output logic                          s_axi_rvalid_out,
  input  logic                          s_axi_rready_in,
  output logic [reg_num*datawidth-1:0]  reg_data_out,
  output logic [reg_num-1:0]            reg_wr_pulse_out
);

  localparam int IDXW = $clog2(reg_num);
  localparam int NB   = datawidth / 8;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_GOT_AW = 2'd1,
    W_GOT_W  = 2'd2,
    W_RESP   = 2'd3
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  function automatic logic f_in_range(input logic [addrwidth-1:0] a);
    return ((a >> (IDXW + 2)) == '0);
  endfunction

  function automatic logic [datawidth-1:0] f_merge(
    input logic [datawidth-1:0] old_v,
    input logic [datawidth-1:0] new_v,
    input logic [NB-1:0]        strb
  );
    logic [datawidth-1:0] res;
    res = old_v;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_v[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [reg_num-1:0] f_onehot(input logic [IDXW-1:0] idx);
    logic [reg_num-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  wstate_t               r_wstate;
  wstate_t               w_wstate_nxt;
  rstate_t               r_rstate;
  rstate_t               w_rstate_nxt;
  logic                  r_rst_active;
  logic [addrwidth-1:0]  r_awaddr;
  logic [datawidth-1:0]  r_wdata;
  logic [NB-1:0]         r_wstrb;
  logic [1:0]            r_bresp;
  logic [1:0]            r_rresp;
  logic [datawidth-1:0]  r_rdata;
  logic [reg_num-1:0]    r_wr_pulse;
  logic [datawidth-1:0]  r_regs [reg_num];

  logic                  w_awready;
  logic                  w_wready;
  logic                  w_bvalid;
  logic                  w_arready;
  logic                  w_rvalid;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [addrwidth-1:0]  w_wr_addr;
  logic [datawidth-1:0]  w_wr_data;
  logic [NB-1:0]         w_wr_strb;
  logic                  w_wr_in_range;
  logic [IDXW-1:0]       w_wr_idx;
  logic                  w_rd_in_range;
  logic [IDXW-1:0]       w_rd_idx;

  // Tracks reset so readies can be held low from registered state alone
  always_ff @(posedge s_axi_aclk_in) begin
    if (s_axi_areset_in) begin
      r_rst_active <= 1'b1;
    end else begin
      r_rst_active <= 1'b0;
    end
  end

  // Write channel handshake signals decoded from the write state
  always_comb begin
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = ~r_rst_active;
        w_wready  = ~r_rst_active;
      end
      W_GOT_AW: w_wready  = ~r_rst_active;
      W_GOT_W:  w_awready = ~r_rst_active;
      W_RESP:   w_bvalid  = 1'b1;
      default: begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
      end
    endcase
  end

  assign w_aw_hs = s_axi_awvalid_in & w_awready;
  assign w_w_hs  = s_axi_wvalid_in & w_wready;

  // Write FSM next state
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = W_RESP;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_GOT_AW;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_GOT_W;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_GOT_AW: begin
        if (w_w_hs) begin
          w_wstate_nxt = W_RESP;
        end else begin
          w_wstate_nxt = W_GOT_AW;
        end
      end
      W_GOT_W: begin
        if (w_aw_hs) begin
          w_wstate_nxt = W_RESP;
        end else begin
          w_wstate_nxt = W_GOT_W;
        end
      end
      W_RESP: begin
        if (s_axi_bready_in) begin
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wstate_nxt = W_RESP;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // The second half of a split write arrives live; the first half comes from the holding registers
  assign w_commit      = (r_wstate != W_RESP) && (w_wstate_nxt == W_RESP);
  assign w_wr_addr     = w_aw_hs ? s_axi_awaddr_in : r_awaddr;
  assign w_wr_data     = w_w_hs  ? s_axi_wdata_in  : r_wdata;
  assign w_wr_strb     = w_w_hs  ? s_axi_wstrb_in  : r_wstrb;
  assign w_wr_in_range = f_in_range(w_wr_addr);
  assign w_wr_idx      = w_wr_addr[IDXW+1:2];

  // Write FSM state, captured address/data and write response
  always_ff @(posedge s_axi_aclk_in) begin
    if (s_axi_areset_in) begin
      r_wstate <= W_IDLE;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= 2'b00;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_awaddr <= s_axi_awaddr_in;
      end
      if (w_w_hs) begin
        r_wdata <= s_axi_wdata_in;
        r_wstrb <= s_axi_wstrb_in;
      end
      if (w_commit) begin
        r_bresp <= w_wr_in_range ? 2'b00 : 2'b10;
      end
    end
  end

  // Register bank and per-register write pulse
  always_ff @(posedge s_axi_aclk_in) begin
    if (s_axi_areset_in) begin
      for (int k = 0; k < reg_num; k++) begin
        r_regs[k] <= '0;
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && w_wr_in_range) begin
        r_regs[w_wr_idx] <= f_merge(r_regs[w_wr_idx], w_wr_data, w_wr_strb);
        r_wr_pulse       <= f_onehot(w_wr_idx);
      end
    end
  end

  // Read channel handshake signals decoded from the read state
  always_comb begin
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE:  w_arready = ~r_rst_active;
      R_DATA:  w_rvalid  = 1'b1;
      default: begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
      end
    endcase
  end

  assign w_ar_hs       = s_axi_arvalid_in & w_arready;
  assign w_rd_in_range = f_in_range(s_axi_araddr_in);
  assign w_rd_idx      = s_axi_araddr_in[IDXW+1:2];

  // Read FSM next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_DATA;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_DATA: begin
        if (s_axi_rready_in) begin
          w_rstate_nxt = R_IDLE;
        end else begin
          w_rstate_nxt = R_DATA;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM state and read data; a same-edge write is not yet visible in r_regs
  always_ff @(posedge s_axi_aclk_in) begin
    if (s_axi_areset_in) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        if (w_rd_in_range) begin
          r_rdata <= r_regs[w_rd_idx];
          r_rresp <= 2'b00;
        end else begin
          r_rdata <= '0;
          r_rresp <= 2'b10;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < reg_num; g++) begin : g_flat
      assign reg_data_out[g*datawidth +: datawidth] = r_regs[g];
    end
  endgenerate

  assign s_axi_awready_out = w_awready;
  assign s_axi_wready_out  = w_wready;
  assign s_axi_bvalid_out  = w_bvalid;
  assign s_axi_bresp_out   = r_bresp;
  assign s_axi_arready_out = w_arready;
  assign s_axi_rvalid_out  = w_rvalid;
  assign s_axi_rdata_out   = r_rdata;
  assign s_axi_rresp_out   = r_rresp;
  assign reg_wr_pulse_out  = r_wr_pulse;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Randomized bench for axi4_lite_slave_regs against an array-based register model.
module tb_axi4_lite_slave_regs;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   awaddr, wdata, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]    wstrb;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [511:0]  reg_data;
  logic [15:0]   pulse;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   m_regs [16];

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.datawidth(32), .addrwidth(32), .reg_num(16)) dut (
    .s_axi_aclk_in(clk),          .s_axi_areset_in(rst),
    .s_axi_awaddr_in(awaddr),     .s_axi_awvalid_in(awvalid),   .s_axi_awready_out(awready),
    .s_axi_wdata_in(wdata),       .s_axi_wstrb_in(wstrb),       .s_axi_wvalid_in(wvalid),
    .s_axi_wready_out(wready),    .s_axi_bresp_out(bresp),      .s_axi_bvalid_out(bvalid),
    .s_axi_bready_in(bready),     .s_axi_araddr_in(araddr),     .s_axi_arvalid_in(arvalid),
    .s_axi_arready_out(arready),  .s_axi_rdata_out(rdata),      .s_axi_rresp_out(rresp),
    .s_axi_rvalid_out(rvalid),    .s_axi_rready_in(rready),
    .reg_data_out(reg_data),      .reg_wr_pulse_out(pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_regs(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk(tag, reg_data[k*32 +: 32], m_regs[k]);
    end
  endtask

  function automatic bit in_bank(input logic [31:0] a);
    return (a / 32'd64) == 32'd0;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_start, input int w_start, input int bdelay);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_fire, w_fire;
    int cyc = 0;
    int idx;
    logic [1:0]  exp_resp;
    logic [15:0] exp_pulse;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = (cyc >= aw_start) && !aw_done;
      wvalid  = (cyc >= w_start) && !w_done;
      @(negedge clk);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      cyc++;
      if (!(aw_done && w_done)) begin
        chk("bvalid_early", bvalid, 1'b0);
        if (aw_done) chk("awready_after_aw", awready, 1'b0);
        if (w_done)  chk("wready_after_w", wready, 1'b0);
      end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      chk("wr_timeout", {30'd0, aw_done, w_done}, 32'd3);
      return;
    end
    if (in_bank(addr)) begin
      idx = int'(addr / 32'd4);
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
      end
      exp_pulse = 16'd1 << idx;
      exp_resp  = 2'b00;
    end else begin
      exp_pulse = 16'd0;
      exp_resp  = 2'b10;
    end
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp);
    chk("wr_pulse", pulse, exp_pulse);
    chk("resp_awready", awready, 1'b0);
    chk("resp_wready", wready, 1'b0);
    chk_all_regs("reg_after_wr");
    for (int d = 0; d < bdelay; d++) begin
      bready = 1'b0;
      tick();
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, exp_resp);
      chk("pulse_once", pulse, 16'd0);
      chk("awready_hold", awready, 1'b0);
      chk("wready_hold", wready, 1'b0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_release", bvalid, 1'b0);
    chk("awready_release", awready, 1'b1);
    chk("wready_release", wready, 1'b1);
    chk("pulse_after", pulse, 16'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_start, input int rdelay);
    bit ar_done = 1'b0;
    bit ar_fire;
    int cyc = 0;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = in_bank(addr) ? m_regs[int'(addr / 32'd4)] : 32'd0;
    exp_resp = in_bank(addr) ? 2'b00 : 2'b10;
    araddr = addr;
    while (!ar_done && cyc < 40) begin
      arvalid = (cyc >= ar_start);
      @(negedge clk);
      ar_fire = arvalid && arready;
      tick();
      ar_done = ar_fire;
      cyc++;
      if (!ar_done) chk("rvalid_early", rvalid, 1'b0);
    end
    arvalid = 1'b0;
    if (!ar_done) begin
      chk("rd_timeout", {31'd0, ar_done}, 32'd1);
      return;
    end
    chk("rvalid", rvalid, 1'b1);
    chk("rdata", rdata, exp_data);
    chk("rresp", rresp, exp_resp);
    chk("arready_busy", arready, 1'b0);
    for (int d = 0; d < rdelay; d++) begin
      rready = 1'b0;
      tick();
      chk("rvalid_hold", rvalid, 1'b1);
      chk("rdata_hold", rdata, exp_data);
      chk("rresp_hold", rresp, exp_resp);
      chk("arready_hold", arready, 1'b0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_release", rvalid, 1'b0);
    chk("arready_release", arready, 1'b1);
  endtask

  initial begin
    logic [31:0] a, d, old5, new5;
    rst = 1'b1;
    awaddr = 32'd0; wdata = 32'd0; wstrb = 4'd0; araddr = 32'd0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int k = 0; k < 16; k++) m_regs[k] = 32'd0;
    repeat (3) tick();
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulse", pulse, 16'd0);
    chk_all_regs("rst_regs");
    rst = 1'b0;
    tick();
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_wready", wready, 1'b1);
    chk("post_rst_arready", arready, 1'b1);

    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk("reg1_deadbeef", reg_data[63:32], 32'hDEADBEEF);
    axi_read(32'h04, 0, 0);

    axi_write(32'h08, 32'h12345678, 4'hF, 3, 0, 1);
    axi_write(32'h08, 32'h12345678, 4'hF, 0, 3, 2);
    chk("reg2_value", reg_data[95:64], 32'h12345678);

    axi_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(32'h0C, 32'h00000000, 4'h5, 0, 0, 0);
    chk("reg3_partial", reg_data[127:96], 32'hFF00FF00);

    axi_write(32'h40, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    axi_read(32'h40, 0, 0);

    axi_write(32'h10, $urandom, 4'hF, 0, 0, 10);
    axi_read(32'h10, 0, 10);

    // Write and read of the same register accepted on one edge
    old5 = m_regs[5];
    new5 = ~old5 ^ 32'h0F0F_0001;
    awaddr = 32'h14; wdata = new5; wstrb = 4'hF; araddr = 32'h14;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    m_regs[5] = new5;
    chk("hazard_rvalid", rvalid, 1'b1);
    chk("hazard_rdata_old", rdata, old5);
    chk("hazard_bvalid", bvalid, 1'b1);
    chk("hazard_reg_new", reg_data[191:160], new5);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("hazard_bvalid_rel", bvalid, 1'b0);
    chk("hazard_rvalid_rel", rvalid, 1'b0);

    // Reset while holding a write address
    awaddr = 32'h3C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("got_aw_awready", awready, 1'b0);
    chk("got_aw_wready", wready, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    chk("midrst_wready", wready, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) m_regs[k] = 32'd0;
    tick();
    chk_all_regs("after_midrst");
    axi_write(32'h00, 32'hCAFEF00D, 4'hF, 2, 0, 0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(1, 255) << 6) | $urandom_range(0, 63);
      else a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      d = $urandom;
      axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom_range(1, 1023) << 6;
      else a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
